pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: payload width in bits (stage data such as ALU result, memory read data, next PC).
REQ-002 The block SHALL have parameter CTRL_W, default 8: control-bit width (write enable, mux selects, instruction type), cleared on flush.
REQ-003 The block SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the falling edge of clk.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: kills all held entries (turns them into bubbles).
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream entry present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: stage accepts an entry this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control bits.
REQ-011 The block SHALL have port out_valid, output, 1 bit: downstream entry present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: head payload.
REQ-014 The block SHALL have port out_ctrl, output, CTRL_W bits: head control bits, forced to 0 when out_valid=0.
REQ-015 The block SHALL have port stall_cnt, output, CNT_W bits: count of stalled cycles.

Function
REQ-016 A transfer SHALL occur on a falling edge where the valid and ready of that side are both 1; entries SHALL leave in arrival order, none lost or duplicated.
REQ-017 Input-to-output latency SHALL be exactly one falling edge when the stage is empty.
REQ-018 The buffer SHALL have states EMPTY, ONE and TWO; TWO exists only with the skid option.
REQ-019 In EMPTY, an input transfer SHALL move the state to ONE.
REQ-020 In ONE, input transfer without output transfer SHALL move to TWO (skid) or be impossible (no skid); output without input SHALL move to EMPTY; both together SHALL stay in ONE, with the head replaced by the new entry.
REQ-021 In TWO, an output transfer SHALL move to ONE, with the skid entry promoted to head.
REQ-022 out_valid SHALL be 1 in ONE and TWO only; the stage SHALL hold its head stable while out_valid=1 and out_ready=0.
REQ-023 flush=1 SHALL force the next state to EMPTY and clear all ctrl storage to 0, and SHALL discard any concurrent input or output transfer; data storage SHALL be left unchanged.
REQ-024 flush and reset asserted together SHALL behave as reset.
REQ-025 stall_cnt SHALL increment on each falling edge with out_valid=1 and out_ready=0, SHALL saturate at all-ones (no wrap), and SHALL NOT be affected by flush.

Reset
REQ-026 While reset=1 at a falling edge, the stage SHALL go to EMPTY and clear out_data, out_ctrl, skid storage and stall_cnt to 0, with out_valid=0.
REQ-027 Reset asserted mid-transfer SHALL drop all held entries; in_ready SHALL read 1 in the cycle after reset deasserts.

Configuration
REQ-028 With macro PIPE_STAGE_REG_SKID_EN defined, the stage SHALL contain a second skid entry, and in_ready SHALL be a registered signal equal to (state != TWO), with no combinational path from out_ready.
REQ-029 With PIPE_STAGE_REG_SKID_EN undefined, the stage SHALL contain one entry only, with in_ready = out_ready OR NOT out_valid (combinational); full throughput SHALL be kept in both builds.

Verification
REQ-030 Reset: hold reset=1 for 2 edges, then deassert -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1.
REQ-031 Streaming: in_valid=1 with in_data=1..8 and out_ready=1 throughout -> out_data=1..8 on consecutive edges, one-edge latency, stall_cnt=0.
REQ-032 Backpressure: with skid enabled, push 0xA then 0xB with out_ready=0 -> state TWO, in_ready=0; raise out_ready -> 0xA then 0xB out, in order; stall_cnt equals the number of stalled edges.
REQ-033 Flush: from TWO with in_valid=1, assert flush for 1 edge -> out_valid=0, out_ctrl=0, input entry dropped, stall_cnt unchanged.
REQ-034 Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 edges -> stall_cnt=15, with no wrap.
REQ-035 Reset mid-operation: assert reset while in ONE with in_valid=1 -> state EMPTY next edge and the input entry never appears at the output.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage with valid/ready handshaking,
// flush-to-bubble, and a saturating count of stalled cycles.
// All state changes on the falling edge of clk; reset is synchronous.
// Optional macro PIPE_STAGE_REG_SKID_EN adds a second (skid) entry and makes
// in_ready a register. Without it, in_ready depends combinationally on out_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               in_fire;
  logic               out_fire;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic               in_ready_q, in_ready_d;

  // Registered ready: the stage can take one more entry unless both slots are full.
  assign in_ready = in_ready_q;
`else
  // Single entry: accept when empty or when the head leaves on this same edge.
  assign in_ready = out_ready | ~out_valid;
`endif

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = head_data_q;
  assign out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state, storage update and stall counting; flush overrides the buffer moves.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    stall_cnt_d = stall_cnt_q;
`ifdef PIPE_STAGE_REG_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d     = ST_ONE;
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          // Head leaves and the new entry takes its place.
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
`ifdef PIPE_STAGE_REG_SKID_EN
        end else if (in_fire) begin
          // Downstream is stalled: park the new entry behind the head.
          state_d     = ST_TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
`endif
        end
      end
      ST_TWO: begin
`ifdef PIPE_STAGE_REG_SKID_EN
        if (out_fire) begin
          state_d     = ST_ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
        end
`else
        state_d = ST_EMPTY;
`endif
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush turns everything into bubbles; payload bits are left as they are.
    if (flush) begin
      state_d     = ST_EMPTY;
      head_data_d = head_data_q;
      head_ctrl_d = '0;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_data_d = skid_data_q;
      skid_ctrl_d = '0;
`endif
    end

    // Count edges where the head is offered but refused; stick at all-ones.
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    in_ready_d = (state_d != ST_TWO);
`endif
  end

  // State and storage registers, falling-edge clocked with synchronous reset.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      stall_cnt_q <= '0;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: reset check, table of directed vectors
// (streaming, backpressure, flush, reset mid-operation) and a stall-counter
// saturation sequence. Expectations follow the build selected by
// PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam logic [3:0] SCB  = 4'd4;  // stall count left after flush section
  localparam logic       IR_R = 1'b1;  // in_ready in ONE with stalled head
`else
  localparam logic [3:0] SCB  = 4'd2;
  localparam logic       IR_R = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W(32),
    .CTRL_W(8),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic [7:0]  ic;
    logic        orr;
    logic        chk_ir;
    logic        exp_ir;
    logic        exp_ov;
    logic        chk_od;
    logic [31:0] exp_od;
    logic [7:0]  exp_oc;
    logic [3:0]  exp_sc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] id, input logic [7:0] ic,
                              input logic orr, input logic chk_ir, input logic exp_ir,
                              input logic exp_ov, input logic chk_od,
                              input logic [31:0] exp_od, input logic [7:0] exp_oc,
                              input logic [3:0] exp_sc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.orr = orr;
    v.chk_ir = chk_ir; v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.chk_od = chk_od;
    v.exp_od = exp_od; v.exp_oc = exp_oc; v.exp_sc = exp_sc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  c;
    logic [3:0]  exp_sc;

    // ---- vector table ----
    // streaming 1..8, one-edge latency, no stalls
    for (int i = 1; i <= 8; i++) begin
      d = 32'(i);
      c = 8'h10 + 8'(i);
      vq.push_back(mk(N, N, Y, d, c, Y, Y, Y, Y, Y, d, c, 4'd0));
    end
    vq.push_back(mk(N, N, N, 32'h0, 8'h0, Y, Y, Y, N, N, 32'h0, 8'h0, 4'd0));
`ifdef PIPE_STAGE_REG_SKID_EN
    // backpressure into the skid slot, then drain in order
    vq.push_back(mk(N, N, Y, 32'hA, 8'hAA, N, Y, Y, Y, Y, 32'hA, 8'hAA, 4'd0));
    vq.push_back(mk(N, N, Y, 32'hB, 8'hBB, N, Y, Y, Y, Y, 32'hA, 8'hAA, 4'd1));
    vq.push_back(mk(N, N, Y, 32'hC, 8'hCC, N, Y, N, Y, Y, 32'hA, 8'hAA, 4'd2));
    vq.push_back(mk(N, N, N, 32'h0, 8'h0,  N, Y, N, Y, Y, 32'hA, 8'hAA, 4'd3));
    vq.push_back(mk(N, N, N, 32'h0, 8'h0,  Y, Y, N, Y, Y, 32'hB, 8'hBB, 4'd3));
    vq.push_back(mk(N, N, N, 32'h0, 8'h0,  Y, Y, Y, N, N, 32'h0, 8'h0,  4'd3));
    // flush from TWO with an input offered
    vq.push_back(mk(N, N, Y, 32'hD, 8'hDD, N, Y, Y, Y, Y, 32'hD, 8'hDD, 4'd3));
    vq.push_back(mk(N, N, Y, 32'hE, 8'hEE, N, Y, Y, Y, Y, 32'hD, 8'hDD, 4'd4));
    vq.push_back(mk(N, Y, Y, 32'hF, 8'hFF, Y, Y, N, N, Y, 32'hD, 8'h0,  4'd4));
    vq.push_back(mk(N, N, N, 32'h0, 8'h0,  Y, Y, Y, N, N, 32'h0, 8'h0,  4'd4));
`else
    // backpressure on a single entry: B waits until A leaves
    vq.push_back(mk(N, N, Y, 32'hA, 8'hAA, N, Y, Y, Y, Y, 32'hA, 8'hAA, 4'd0));
    vq.push_back(mk(N, N, Y, 32'hB, 8'hBB, N, Y, N, Y, Y, 32'hA, 8'hAA, 4'd1));
    vq.push_back(mk(N, N, Y, 32'hB, 8'hBB, N, Y, N, Y, Y, 32'hA, 8'hAA, 4'd2));
    vq.push_back(mk(N, N, Y, 32'hB, 8'hBB, Y, Y, Y, Y, Y, 32'hB, 8'hBB, 4'd2));
    vq.push_back(mk(N, N, N, 32'h0, 8'h0,  Y, Y, Y, N, N, 32'h0, 8'h0,  4'd2));
    // flush with concurrent input and output transfer
    vq.push_back(mk(N, N, Y, 32'hD, 8'hDD, N, Y, Y, Y, Y, 32'hD, 8'hDD, 4'd2));
    vq.push_back(mk(N, Y, Y, 32'hE, 8'hEE, Y, Y, Y, N, Y, 32'hD, 8'h0,  4'd2));
    vq.push_back(mk(N, N, N, 32'h0, 8'h0,  Y, Y, Y, N, N, 32'h0, 8'h0,  4'd2));
`endif
    // reset (together with flush) while in ONE with an input offered
    vq.push_back(mk(N, N, Y, 32'h1234, 8'h77, N, Y, Y,    Y, Y, 32'h1234, 8'h77, SCB));
    vq.push_back(mk(Y, Y, Y, 32'h5678, 8'h88, N, Y, IR_R, N, Y, 32'h0,    8'h0,  4'd0));
    vq.push_back(mk(N, N, N, 32'h0,    8'h0,  Y, Y, Y,    N, N, 32'h0,    8'h0,  4'd0));
    vq.push_back(mk(N, N, N, 32'h0,    8'h0,  Y, Y, Y,    N, N, 32'h0,    8'h0,  4'd0));

    // ---- reset ----
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    $display("reset: ov=%0b od=%0h oc=%0h sc=%0d ir=%0b", out_valid, out_data, out_ctrl, stall_cnt, in_ready);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_ctrl",  32'(out_ctrl),  32'd0);
    check("reset_out_data",  out_data,       32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);

    // ---- table ----
    foreach (vq[k]) begin
      reset = vq[k].rst; flush = vq[k].fl; in_valid = vq[k].iv;
      in_data = vq[k].id; in_ctrl = vq[k].ic; out_ready = vq[k].orr;
      @(posedge clk);
      if (vq[k].chk_ir) check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vq[k].exp_ir));
      tick();
      $display("vec %0d: rst=%0b fl=%0b iv=%0b id=%0h or=%0b -> ov=%0b od=%0h oc=%0h sc=%0d",
               k, vq[k].rst, vq[k].fl, vq[k].iv, vq[k].id, vq[k].orr,
               out_valid, out_data, out_ctrl, stall_cnt);
      check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vq[k].exp_ov));
      check($sformatf("vec%0d_out_ctrl", k),  32'(out_ctrl),  32'(vq[k].exp_oc));
      check($sformatf("vec%0d_stall_cnt", k), 32'(stall_cnt), 32'(vq[k].exp_sc));
      if (vq[k].chk_od) check($sformatf("vec%0d_out_data", k), out_data, vq[k].exp_od);
    end

    // ---- stall counter saturation ----
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h99; in_ctrl = 8'h99; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    $display("sat load: ov=%0b od=%0h sc=%0d", out_valid, out_data, stall_cnt);
    check("sat_load_out_valid", 32'(out_valid), 32'd1);
    check("sat_load_stall_cnt", 32'(stall_cnt), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_sc = (k > 15) ? 4'd15 : 4'(k);
      $display("sat edge %0d: sc=%0d ov=%0b od=%0h", k, stall_cnt, out_valid, out_data);
      check($sformatf("sat%0d_stall_cnt", k), 32'(stall_cnt), 32'(exp_sc));
    end
    check("sat_hold_out_data", out_data, 32'h99);
    check("sat_hold_out_ctrl", 32'(out_ctrl), 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
